// File: rtl/seq_link_pkg.sv
// Definitions shared by both ends of the "101" sync-marker serial link:
// state encoding, marker pattern and the parity helper.
package seq_link_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SYNC = 3'd1,
    ST_DATA = 3'd2,
    ST_PAR  = 3'd3,
    ST_GAP  = 3'd4
  } state_t;

  localparam logic [2:0] SYNC_PATTERN = 3'b101;
  localparam int         SYNC_LEN     = 3;

  // Callers zero-extend narrower words; the extra zeros do not change the result.
  function automatic logic even_parity(input logic [31:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/seq_tx_shreg.sv
// Loadable MSB-first shift register holding the word being serialised.
module seq_tx_shreg #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              load,
  input  logic              shift,
  input  logic [DATA_W-1:0] load_data,
  output logic              msb
);

  logic [DATA_W-1:0] word;

  always_ff @(posedge clk) begin
    if (load) begin
      word <= load_data;
    end else if (shift) begin
      word <= word << 1;
    end
  end

  assign msb = word[DATA_W-1];

endmodule

// File: rtl/seq_tx.sv
// Serial frame transmitter: 1-0-1 marker, data MSB first, optional even parity
// (compile with SEQ_TX_PARITY_EN), then GAP idle zeros.
module seq_tx
  import seq_link_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int GAP    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              tx_out,
  output logic              tx_active,
  output logic              frame_done
);

`ifdef SEQ_TX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  localparam logic [4:0] LAST_BIT  = 5'(DATA_W - 1);
  localparam logic [4:0] LAST_SYNC = 5'(SYNC_LEN - 1);
  localparam logic [3:0] LAST_GAP  = (GAP > 0) ? 4'(GAP - 1) : 4'd0;
  // With a one-bit payload and no parity, the first data bit is also the last frame bit.
  localparam bit DONE_AT_DATA_ENTRY = (DATA_W == 1) && !PAR_EN;

  state_t     state;
  logic [4:0] bit_cnt;
  logic [3:0] gap_cnt;
  logic       load;
  logic       shift;
  logic       msb;

  assign in_ready = (state == ST_IDLE) && !rst;
  assign load     = in_ready && in_valid;
  // Advance the register whenever its MSB is moved onto the line.
  assign shift    = ((state == ST_SYNC) && (bit_cnt == LAST_SYNC)) ||
                    ((state == ST_DATA) && (bit_cnt != LAST_BIT));

  seq_tx_shreg #(.DATA_W(DATA_W)) u_shreg (
    .clk       (clk),
    .load      (load),
    .shift     (shift),
    .load_data (in_data),
    .msb       (msb)
  );

`ifdef SEQ_TX_PARITY_EN
  logic par_bit;

  always_ff @(posedge clk) begin
    if (load) begin
      par_bit <= even_parity(32'(in_data));
    end
  end
`endif

  // Outputs are registered: the state names the bit currently on tx_out.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      bit_cnt    <= '0;
      gap_cnt    <= '0;
      tx_out     <= 1'b0;
      tx_active  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            state     <= ST_SYNC;
            bit_cnt   <= '0;
            tx_out    <= SYNC_PATTERN[2];
            tx_active <= 1'b1;
          end else begin
            tx_out    <= 1'b0;
            tx_active <= 1'b0;
          end
        end
        ST_SYNC: begin
          if (bit_cnt == LAST_SYNC) begin
            state      <= ST_DATA;
            bit_cnt    <= '0;
            tx_out     <= msb;
            frame_done <= DONE_AT_DATA_ENTRY;
          end else begin
            bit_cnt <= bit_cnt + 5'd1;
            tx_out  <= SYNC_PATTERN[2'd1 - bit_cnt[1:0]];
          end
        end
        ST_DATA: begin
          if (bit_cnt == LAST_BIT) begin
`ifdef SEQ_TX_PARITY_EN
            state      <= ST_PAR;
            tx_out     <= par_bit;
            frame_done <= 1'b1;
`else
            state     <= (GAP > 0) ? ST_GAP : ST_IDLE;
            gap_cnt   <= '0;
            tx_out    <= 1'b0;
            tx_active <= 1'b0;
`endif
          end else begin
            bit_cnt    <= bit_cnt + 5'd1;
            tx_out     <= msb;
            frame_done <= !PAR_EN && (bit_cnt == LAST_BIT - 5'd1);
          end
        end
`ifdef SEQ_TX_PARITY_EN
        ST_PAR: begin
          state     <= (GAP > 0) ? ST_GAP : ST_IDLE;
          gap_cnt   <= '0;
          tx_out    <= 1'b0;
          tx_active <= 1'b0;
        end
`endif
        ST_GAP: begin
          tx_out    <= 1'b0;
          tx_active <= 1'b0;
          if (gap_cnt == LAST_GAP) begin
            state <= ST_IDLE;
          end else begin
            gap_cnt <= gap_cnt + 4'd1;
          end
        end
        default: begin
          state     <= ST_IDLE;
          tx_out    <= 1'b0;
          tx_active <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_tx.sv
// Bench for seq_tx: two instances (GAP=2 and GAP=0) against a cycle-offset frame model.
module tb_seq_tx;

  localparam int DW = 8;
`ifdef SEQ_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int NTR = 2048;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic [1:0]    rdy, tx, act, done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit started = 1'b0;

  // Model state per instance: accepted word and the cycle of its first sync bit.
  bit            busy  [2];
  int            start [2];
  logic [DW-1:0] word  [2];
  int            gapv  [2];

  logic tr_tx   [2][NTR];
  logic tr_done [2][NTR];
  logic tr_rdy  [2][NTR];

  always #5 clk = ~clk;

  seq_tx #(.DATA_W(DW), .GAP(2)) dut0 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy[0]), .tx_out(tx[0]), .tx_active(act[0]), .frame_done(done[0]));

  seq_tx #(.DATA_W(DW), .GAP(0)) dut1 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy[1]), .tx_out(tx[1]), .tx_active(act[1]), .frame_done(done[1]));

  task automatic chk(input string nm, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, actual, expected, cyc);
    end
  endtask

  function automatic bit model_idle(input int u, input int c);
    return !busy[u] || (c - start[u] >= 3 + DW + P + gapv[u]);
  endfunction

  // Expected {tx_out, tx_active, frame_done, in_ready} in cycle c.
  function automatic logic [3:0] model_out(input int u, input int c);
    int o;
    if (model_idle(u, c)) return {3'b000, !rst};
    o = c - start[u];
    if (o < 3) return {logic'(o != 1), 1'b1, 1'b0, 1'b0};
    if (o < 3 + DW) return {word[u][DW-1-(o-3)], 1'b1, logic'(P == 0 && o == 2 + DW), 1'b0};
    if (P == 1 && o == 3 + DW) return {^word[u], 1'b1, 1'b1, 1'b0};
    return 4'b0000;
  endfunction

  always @(posedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (rst) begin
        busy[u] = 1'b0;
      end else if (in_valid && model_idle(u, cyc)) begin
        busy[u]  = 1'b1;
        start[u] = cyc + 1;
        word[u]  = in_data;
      end
    end
    cyc = cyc + 1;
    started = 1'b1;
  end

  always @(negedge clk) begin
    logic [3:0] e;
    #2;
    if (started) begin
      for (int u = 0; u < 2; u++) begin
        e = model_out(u, cyc);
        chk($sformatf("u%0d tx_out", u), int'(tx[u]), int'(e[3]));
        chk($sformatf("u%0d tx_active", u), int'(act[u]), int'(e[2]));
        chk($sformatf("u%0d frame_done", u), int'(done[u]), int'(e[1]));
        chk($sformatf("u%0d in_ready", u), int'(rdy[u]), int'(e[0]));
        if (cyc < NTR) begin
          tr_tx[u][cyc]   = tx[u];
          tr_done[u][cyc] = done[u];
          tr_rdy[u][cyc]  = rdy[u];
        end
      end
    end
  end

  function automatic logic [31:0] bits(input int u, input int from, input int n);
    logic [31:0] v = '0;
    for (int i = 0; i < n; i++) v = {v[30:0], tr_tx[u][from+i]};
    return v;
  endfunction

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic wait_ready(input int u);
    int n = 0;
    #1;
    while (!rdy[u] && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!rdy[u]) begin
      checks++;
      errors++;
      $display("FAIL wait_ready u%0d: in_ready got 0 expected 1 within 100 cycles", u);
    end
  endtask

  task automatic send(input int u, input logic [DW-1:0] d, output int k);
    wait_ready(u);
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk);
    #1 k = cyc;
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = DW'($urandom);
  endtask

  initial begin
    int k, k2, r, n, any_done;
    gapv[0] = 2;
    gapv[1] = 0;

    // Reset with in_valid held high.
    rst = 1'b1;
    in_valid = 1'b1;
    in_data = 8'h5A;
    repeat (3) @(negedge clk);
    #1;
    for (int u = 0; u < 2; u++) begin
      chk($sformatf("rst u%0d tx_out", u), int'(tx[u]), 0);
      chk($sformatf("rst u%0d in_ready", u), int'(rdy[u]), 0);
      chk($sformatf("rst u%0d frame_done", u), int'(done[u]), 0);
    end
    rst = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("rdy_after_rst u0", int'(rdy[0]), 1);
    chk("rdy_after_rst u1", int'(rdy[1]), 1);

    // Single word 0xA5 on the GAP=2 instance.
    @(negedge clk);
    send(0, 8'hA5, k);
    wait_until(k + 20);
    chk("a5_bits", int'(bits(0, k, 11)), int'(11'b10110100101));
    chk("a5_done_last", int'(tr_done[0][k+10+P]), 1);
    chk("a5_done_early", int'(tr_done[0][k+9+P]), 0);
    r = k + 1;
    while (r < k + 40 && !tr_rdy[0][r]) r++;
`ifdef SEQ_TX_PARITY_EN
    chk("a5_parity", int'(tr_tx[0][k+11]), 0);
    chk("a5_period", r + 1 - k, 15);
`else
    chk("a5_period", r + 1 - k, 14);
`endif

    // 0x01: parity bit 1 when enabled, otherwise first gap zero.
    send(0, 8'h01, k);
    wait_until(k + 16);
    chk("w01_bits", int'(bits(0, k, 11)), int'(11'b10100000001));
`ifdef SEQ_TX_PARITY_EN
    chk("w01_parity", int'(tr_tx[0][k+11]), 1);
`else
    chk("w01_after_lsb", int'(tr_tx[0][k+11]), 0);
`endif

    // Back-to-back on the GAP=0 instance with in_valid held high.
    wait_ready(1);
    in_valid = 1'b1;
    in_data = 8'hFF;
    @(posedge clk);
    #1 k = cyc;
    @(negedge clk);
    in_data = 8'h00;
    n = 0;
    #1;
    while (!rdy[1] && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!rdy[1]) begin
      checks++;
      errors++;
      $display("FAIL b2b_wait: in_ready got 0 expected 1 within 40 cycles");
    end
    @(posedge clk);
    #1 k2 = cyc;
    @(negedge clk);
    in_valid = 1'b0;
    wait_until(k2 + 14);
`ifdef SEQ_TX_PARITY_EN
    chk("b2b_period", k2 - k, 13);
    chk("b2b_bits", int'(bits(1, k, 24)), int'(24'b101111111110010100000000));
`else
    chk("b2b_period", k2 - k, 12);
    chk("b2b_bits", int'(bits(1, k, 23)), int'(23'b10111111111010100000000));
`endif

    // Reset during the third data bit of 0xC3.
    wait_until(cyc + 20);
    send(0, 8'hC3, k);
    wait_until(k + 5);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    wait_until(k + 16);
    chk("midrst_tx", int'(tr_tx[0][k+6]), 0);
    any_done = 0;
    for (int i = k; i < k + 16; i++) any_done |= int'(tr_done[0][i]);
    chk("midrst_no_done", any_done, 0);
    send(0, 8'h3C, k);
    wait_until(k + 16);
    chk("after_rst_bits", int'(bits(0, k, 11)), int'(11'b10100111100));

    // Hold-off: a second word offered mid-frame is ignored.
    send(0, 8'h5A, k);
    wait_until(k + 6);
    in_valid = 1'b1;
    in_data = 8'h99;
    @(negedge clk);
    in_valid = 1'b0;
    wait_until(k + 16);
    chk("holdoff_bits", int'(bits(0, k, 11)), int'(11'b10101011010));

    // Randomised traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      rst      = ($urandom_range(0, 49) == 0);
      in_valid = ($urandom_range(0, 2) == 0);
      in_data  = DW'($urandom);
    end
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    repeat (30) @(negedge clk);
    #3;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
